// File: rtl/mem_if_pkg.sv
// Shared types and constants for the core-side memory responder.
// Backend address is one bit wider than the core word address.
package mem_if_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_HOLD,
        S_FETCH_LO,
        S_FETCH_HI,
        S_DONE
    } state_t;

    localparam logic [15:0] TO_FILL_DATA  = 16'hFFFF;
    localparam logic [31:0] TO_FILL_INSTR = 32'hFFFF_FFFF;

    function automatic int mem_baddr_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side request/response bus of the memory responder.
// The core is master; the responder is slave.
interface mem_responder_if #(
    parameter int ADDR_W = 16
);

    logic              req_read;
    logic              req_write;
    logic              req_instr;
    logic              req_read_done;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic [15:0]       rsp_rdata;
    logic [31:0]       rsp_instr;
    logic              rsp_busy;
    logic              rsp_cack;
    logic              rsp_ready;
    logic              rsp_err;

    modport master (
        output req_read, req_write, req_instr, req_read_done,
        output req_addr, req_wdata,
        input  rsp_rdata, rsp_instr, rsp_busy, rsp_cack,
        input  rsp_ready, rsp_err
    );

    modport slave (
        input  req_read, req_write, req_instr, req_read_done,
        input  req_addr, req_wdata,
        output rsp_rdata, rsp_instr, rsp_busy, rsp_cack,
        output rsp_ready, rsp_err
    );

endinterface

// File: rtl/mem_beat_ctl.sv
// Single-beat backend transactor: raises req on start, drops it on
// ack or after TIMEOUT unanswered cycles.
module mem_beat_ctl #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic done,
    output logic timeout
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    // ack seen while req is low never completes a beat
    assign done    = req & ack;
    assign timeout = req & ~ack & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            req <= 1'b0;
            cnt <= 8'd0;
        end else if (start) begin
            req <= 1'b1;
            cnt <= 8'd0;
        end else if (done || timeout) begin
            req <= 1'b0;
        end else if (req) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Target-side endpoint of the core memory bus, serving data reads,
// writes and two-beat instruction fetches from a 16-bit backend.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    mem_responder_if.slave                 core,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic                           mem_space,
    output logic [mem_baddr_w(ADDR_W)-1:0] mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_ack
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic              hi_start;
    logic              any_req;
    logic              fetch_acc;
    logic              start;
    logic              beat_done;
    logic              beat_to;

    assign any_req   = core.req_read | core.req_write;
    assign fetch_acc = core.req_read & ~core.req_write & core.req_instr;
    // hi_start leaves exactly one idle cycle between fetch beats
    assign start     = ((state == S_IDLE) & any_req) | hi_start;

    mem_beat_ctl #(
        .TIMEOUT (TIMEOUT)
    ) u_beat (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ack     (mem_ack),
        .req     (mem_req),
        .done    (beat_done),
        .timeout (beat_to)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            addr_q         <= '0;
            wr_q           <= 1'b0;
            hi_start       <= 1'b0;
            mem_we         <= 1'b0;
            mem_space      <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            core.rsp_rdata <= '0;
            core.rsp_instr <= '0;
            core.rsp_busy  <= 1'b0;
            core.rsp_cack  <= 1'b0;
            core.rsp_ready <= 1'b0;
            core.rsp_err   <= 1'b0;
        end else begin
            core.rsp_cack <= 1'b0;
            hi_start      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        core.rsp_cack <= 1'b1;
                        core.rsp_busy <= 1'b1;
                        addr_q        <= core.req_addr;
                        wr_q          <= core.req_write;
                        mem_we        <= core.req_write;
                        mem_wdata     <= core.req_wdata;
                        if (core.req_read && core.req_write) begin
                            core.rsp_err <= 1'b1;
                        end
                        if (fetch_acc) begin
                            state     <= S_FETCH_LO;
                            mem_space <= 1'b1;
                            mem_addr  <= {core.req_addr, 1'b0};
                        end else begin
                            state     <= S_DATA;
                            mem_space <= core.req_instr;
                            mem_addr  <= {1'b0, core.req_addr};
                        end
                    end
                end
                S_DATA: begin
                    if (beat_done) begin
                        core.rsp_busy  <= 1'b0;
                        core.rsp_ready <= 1'b1;
                        if (wr_q) begin
                            state <= S_DONE;
                        end else begin
                            core.rsp_rdata <= mem_rdata;
                            state          <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (core.req_read_done) begin
                        core.rsp_ready <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                S_FETCH_LO: begin
                    if (beat_done) begin
                        core.rsp_instr[15:0] <= mem_rdata;
                        mem_addr             <= {addr_q, 1'b1};
                        hi_start             <= 1'b1;
                        state                <= S_FETCH_HI;
                    end
                end
                S_FETCH_HI: begin
                    if (beat_done) begin
                        core.rsp_instr[31:16] <= mem_rdata;
                        core.rsp_busy         <= 1'b0;
                        core.rsp_ready        <= 1'b1;
                        state                 <= S_DONE;
                    end
                end
                S_DONE: begin
                    core.rsp_ready <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // only reachable in a beat state, where done and timeout exclude
            if (beat_to) begin
                core.rsp_err   <= 1'b1;
                core.rsp_busy  <= 1'b0;
                core.rsp_ready <= 1'b1;
                state          <= S_DONE;
                if (!wr_q) begin
                    core.rsp_rdata <= TO_FILL_DATA;
                    core.rsp_instr <= TO_FILL_INSTR;
                end
            end
        end
    end

endmodule
